// File: rtl/pq_cmd_shaper.sv
`default_nettype none
// ============================================================================
// Module      : pq_cmd_shaper (with package pq_pkg)
// Description : Command FIFO and issue engine in front of the min-priority
//               queue. Build option PQ_CMD_SHAPER_STATS_EN adds ovf/unf
//               pulse counters.
// Revision    : 1.0 - initial release
// ============================================================================

package pq_pkg;
    typedef struct packed {
        logic [7:0] key;
        logic [7:0] val;
    } kv_t;

    localparam int KVW         = $bits(kv_t);
    localparam int PQ_CAPACITY = 8;
endpackage : pq_pkg

module pq_cmd_shaper #(
    parameter int FIFO_DEPTH = 4,
    parameter int PQ_CAP     = pq_pkg::PQ_CAPACITY,
    parameter int ISSUE_GAP  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [1:0]                  cmd_op,
    input  logic [pq_pkg::KVW-1:0]      cmd_kv,
    output logic                        pq_enq,
    output logic                        pq_deq,
    output logic [pq_pkg::KVW-1:0]      pq_kvi,
    input  logic [pq_pkg::KVW-1:0]      pq_kvo,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [pq_pkg::KVW-1:0]      res_kv,
    output logic                        ovf,
    output logic                        unf,
    output logic [$clog2(PQ_CAP+1)-1:0] count
`ifdef PQ_CMD_SHAPER_STATS_EN
    ,
    output logic [15:0]                 ovf_cnt,
    output logic [15:0]                 unf_cnt
`endif
);

    localparam int c_KVW = pq_pkg::KVW;
    localparam int c_CW  = $clog2(PQ_CAP + 1);
    localparam int c_AW  = $clog2(FIFO_DEPTH);
    localparam int c_PW  = c_AW + 1;

    localparam logic [1:0] c_OP_NOP = 2'b00;
    localparam logic [1:0] c_OP_ENQ = 2'b01;
    localparam logic [1:0] c_OP_DEQ = 2'b10;
    localparam logic [1:0] c_OP_REP = 2'b11;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_GAP   = 2'd2;

    // GAP lasts ISSUE_GAP-1 cycles; the counter runs from ISSUE_GAP-2 down to 0
    localparam logic [1:0] c_GAP_LOAD = (ISSUE_GAP > 1) ? 2'(ISSUE_GAP - 2) : 2'd0;

    // ------------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------------
    logic [1:0]       r_fifo_op [FIFO_DEPTH];
    logic [c_KVW-1:0] r_fifo_kv [FIFO_DEPTH];
    logic [c_PW-1:0]  r_wptr;
    logic [c_PW-1:0]  r_rptr;
    logic [c_PW-1:0]  w_fill;
    logic             w_fifo_empty;
    logic             w_fifo_full;
    logic             w_fifo_one;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_head_op;
    logic [c_KVW-1:0] w_head_kv;

    assign w_fill       = r_wptr - r_rptr;
    assign w_fifo_empty = (r_wptr == r_rptr);
    assign w_fifo_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                          (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign w_fifo_one   = (w_fill == c_PW'(1));
    assign w_head_op    = r_fifo_op[r_rptr[c_AW-1:0]];
    assign w_head_kv    = r_fifo_kv[r_rptr[c_AW-1:0]];

    assign cmd_ready = !w_fifo_full && !rst;
    // Nops complete the handshake but never occupy a slot
    assign w_push    = cmd_valid && cmd_ready && (cmd_op != c_OP_NOP);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_op[r_wptr[c_AW-1:0]] <= cmd_op;
            r_fifo_kv[r_wptr[c_AW-1:0]] <= cmd_kv;
        end
    end

    // ------------------------------------------------------------------------
    // Issue decision for the FIFO head
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [1:0]       r_gap;
    logic [c_CW-1:0]  r_count;
    logic [c_CW-1:0]  w_count_nxt;
    logic             r_res_valid;
    logic [c_KVW-1:0] r_res_kv;
    logic             w_slot_free;
    logic             w_count_zero;
    logic             w_count_full;
    logic             w_enq;
    logic             w_deq;
    logic             w_capture;
    logic             w_ovf;
    logic             w_unf;

    // A result draining this very cycle leaves room for the next capture
    assign w_slot_free  = !r_res_valid || res_ready;
    assign w_count_zero = (r_count == '0);
    assign w_count_full = (r_count == c_CW'(PQ_CAP));

    always_comb begin
        w_pop       = 1'b0;
        w_enq       = 1'b0;
        w_deq       = 1'b0;
        w_capture   = 1'b0;
        w_ovf       = 1'b0;
        w_unf       = 1'b0;
        w_count_nxt = r_count;
        if (r_state == c_ST_ISSUE && !w_fifo_empty) begin
            case (w_head_op)
                c_OP_ENQ: begin
                    w_pop = 1'b1;
                    if (w_count_full) begin
                        w_ovf = 1'b1;
                    end else begin
                        w_enq       = 1'b1;
                        w_count_nxt = r_count + c_CW'(1);
                    end
                end
                c_OP_DEQ: begin
                    if (w_count_zero) begin
                        w_pop = 1'b1;
                        w_unf = 1'b1;
                    end else if (w_slot_free) begin
                        w_pop       = 1'b1;
                        w_deq       = 1'b1;
                        w_capture   = 1'b1;
                        w_count_nxt = r_count - c_CW'(1);
                    end
                end
                c_OP_REP: begin
                    // Replace on an empty queue degenerates to a plain insert
                    if (w_count_zero) begin
                        w_pop       = 1'b1;
                        w_enq       = 1'b1;
                        w_count_nxt = r_count + c_CW'(1);
                    end else if (w_slot_free) begin
                        w_pop     = 1'b1;
                        w_enq     = 1'b1;
                        w_deq     = 1'b1;
                        w_capture = 1'b1;
                    end
                end
                default: begin
                    w_pop = 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Issue engine state machine
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_fifo_empty || w_push) begin
                    w_state_nxt = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                if (w_pop) begin
                    if (ISSUE_GAP > 1) begin
                        w_state_nxt = c_ST_GAP;
                    end else if (w_fifo_one && !w_push) begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end else if (w_fifo_empty && !w_push) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_GAP: begin
                if (r_gap == 2'd0) begin
                    w_state_nxt = (!w_fifo_empty || w_push) ? c_ST_ISSUE : c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_gap   <= 2'd0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_ST_ISSUE && w_state_nxt == c_ST_GAP) begin
                r_gap <= c_GAP_LOAD;
            end else if (r_state == c_ST_GAP && r_gap != 2'd0) begin
                r_gap <= r_gap - 2'd1;
            end
            if (w_push) begin
                r_wptr <= r_wptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PW'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registered queue strobes, occupancy and result slot
    // ------------------------------------------------------------------------
    logic             r_pq_enq;
    logic             r_pq_deq;
    logic [c_KVW-1:0] r_pq_kvi;
    logic             r_ovf;
    logic             r_unf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pq_enq    <= 1'b0;
            r_pq_deq    <= 1'b0;
            r_pq_kvi    <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_count     <= '0;
            r_res_valid <= 1'b0;
            r_res_kv    <= '0;
        end else begin
            r_pq_enq <= w_enq;
            r_pq_deq <= w_deq;
            r_pq_kvi <= w_enq ? w_head_kv : '0;
            r_ovf    <= w_ovf;
            r_unf    <= w_unf;
            r_count  <= w_count_nxt;
            // The minimum is sampled one cycle ahead of the deq strobe it pairs with
            if (w_capture) begin
                r_res_valid <= 1'b1;
                r_res_kv    <= pq_kvo;
            end else if (r_res_valid && res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign pq_enq    = r_pq_enq;
    assign pq_deq    = r_pq_deq;
    assign pq_kvi    = r_pq_kvi;
    assign ovf       = r_ovf;
    assign unf       = r_unf;
    assign count     = r_count;
    assign res_valid = r_res_valid;
    assign res_kv    = r_res_kv;

`ifdef PQ_CMD_SHAPER_STATS_EN
    logic [15:0] r_ovf_cnt;
    logic [15:0] r_unf_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_cnt <= 16'd0;
            r_unf_cnt <= 16'd0;
        end else begin
            if (w_ovf && r_ovf_cnt != 16'hFFFF) begin
                r_ovf_cnt <= r_ovf_cnt + 16'd1;
            end
            if (w_unf && r_unf_cnt != 16'hFFFF) begin
                r_unf_cnt <= r_unf_cnt + 16'd1;
            end
        end
    end

    assign ovf_cnt = r_ovf_cnt;
    assign unf_cnt = r_unf_cnt;
`endif

endmodule : pq_cmd_shaper

`default_nettype wire

// File: tb/tb_pq_cmd_shaper.sv
`default_nettype none
// ============================================================================
// Module      : tb_pq_cmd_shaper
// Description : Directed self-checking bench for pq_cmd_shaper with a
//               behavioural min-queue standing in for the downstream block.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

module tb_pq_cmd_shaper;

    localparam logic [1:0] c_OP_ENQ = 2'b01;
    localparam logic [1:0] c_OP_DEQ = 2'b10;
    localparam logic [1:0] c_OP_REP = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 1: ISSUE_GAP = 1
    logic        rst, cmd_valid, cmd_ready, pq_enq, pq_deq, res_valid, res_ready, ovf, unf;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_kv, pq_kvi, pq_kvo, res_kv;
    logic [2:0]  count;
    // DUT 2: ISSUE_GAP = 3
    logic        rst2, cmd2_valid, cmd2_ready, pq_enq2, pq_deq2, res_valid2, ovf2, unf2;
    logic        res_ready2 = 1'b1;
    logic [1:0]  cmd2_op;
    logic [15:0] cmd2_kv, pq_kvi2, res_kv2;
    logic [15:0] pq_kvo2 = 16'h0000;
    logic [2:0]  count2;
`ifdef PQ_CMD_SHAPER_STATS_EN
    logic [15:0] ovf_cnt, unf_cnt, ovf_cnt2, unf_cnt2;
`endif

    pq_cmd_shaper #(.FIFO_DEPTH(4), .PQ_CAP(4), .ISSUE_GAP(1)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_kv(cmd_kv), .pq_enq(pq_enq), .pq_deq(pq_deq),
        .pq_kvi(pq_kvi), .pq_kvo(pq_kvo), .res_valid(res_valid), .res_ready(res_ready),
        .res_kv(res_kv), .ovf(ovf), .unf(unf), .count(count)
`ifdef PQ_CMD_SHAPER_STATS_EN
        , .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt)
`endif
    );

    pq_cmd_shaper #(.FIFO_DEPTH(4), .PQ_CAP(4), .ISSUE_GAP(3)) u_dut_gap (
        .clk(clk), .rst(rst2), .cmd_valid(cmd2_valid), .cmd_ready(cmd2_ready),
        .cmd_op(cmd2_op), .cmd_kv(cmd2_kv), .pq_enq(pq_enq2), .pq_deq(pq_deq2),
        .pq_kvi(pq_kvi2), .pq_kvo(pq_kvo2), .res_valid(res_valid2), .res_ready(res_ready2),
        .res_kv(res_kv2), .ovf(ovf2), .unf(unf2), .count(count2)
`ifdef PQ_CMD_SHAPER_STATS_EN
        , .ovf_cnt(ovf_cnt2), .unf_cnt(unf_cnt2)
`endif
    );

    // Behavioural downstream min-queue for DUT 1 (ordered by key in bits 15:8)
    logic [15:0] q_kv [8];
    logic [7:0]  q_vld;
    logic [2:0]  q_min, q_free;
    logic [7:0]  q_min_key;
    logic        q_found, q_free_found;

    always_comb begin
        q_min = 3'd0; q_free = 3'd0; q_min_key = 8'hFF;
        q_found = 1'b0; q_free_found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (q_vld[i] && (!q_found || q_kv[i][15:8] < q_min_key)) begin
                q_min = 3'(i); q_min_key = q_kv[i][15:8]; q_found = 1'b1;
            end
            if (!q_vld[i] && !q_free_found) begin
                q_free = 3'(i); q_free_found = 1'b1;
            end
        end
    end

    assign pq_kvo = q_found ? q_kv[q_min] : 16'h0000;

    always @(posedge clk) begin
        if (rst) begin
            q_vld <= 8'h00;
        end else if (pq_enq && pq_deq) begin
            q_kv[q_min] <= pq_kvi;
        end else if (pq_deq) begin
            q_vld[q_min] <= 1'b0;
        end else if (pq_enq) begin
            q_vld[q_free] <= 1'b1;
            q_kv[q_free]  <= pq_kvi;
        end
    end

    int n_enq = 0, n_unf = 0, n_enq2 = 0;
    always @(negedge clk) begin
        if (pq_enq)  n_enq  <= n_enq + 1;
        if (unf)     n_unf  <= n_unf + 1;
        if (pq_enq2) n_enq2 <= n_enq2 + 1;
    end

    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] kv_of(input logic [7:0] k);
        return {k, k ^ 8'hA5};
    endfunction

    // Single deq on DUT 1 with an empty FIFO; result checked on the strobe cycle
    task automatic do_deq(input string tag, input logic [7:0] key, input logic [2:0] cnt);
        cmd_valid = 1'b1; cmd_op = c_OP_DEQ; cmd_kv = 16'h0000;
        tick();
        cmd_valid = 1'b0;
        tick();
        check({tag, "_deq"}, {pq_enq, pq_deq}, 2'b01);
        check({tag, "_res"}, {res_valid, res_kv}, {1'b1, kv_of(key)});
        check({tag, "_cnt"}, count, cnt);
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [1:0]  seq_op  [5];
    logic [7:0]  seq_key [5];
    logic [13:0] strobes;
    logic [15:0] last_kvi;
    int          e0, u0;

    initial begin
        rst = 1'b1; rst2 = 1'b1; res_ready = 1'b1;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_kv = 16'h0000;
        cmd2_valid = 1'b0; cmd2_op = 2'b00; cmd2_kv = 16'h0000;

        // Reset state
        repeat (3) tick();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_strobes", {pq_enq, pq_deq, res_valid, ovf, unf}, 5'b0);
        check("rst_data", {pq_kvi, res_kv}, 32'h0);
        check("rst_count", count, 0);
        rst = 1'b0; rst2 = 1'b0;
        #1;
        check("rel_cmd_ready", cmd_ready, 1);
        tick();

        // Enq 5,3,9 back to back
        u0 = n_unf;
        cmd_valid = 1'b1; cmd_op = c_OP_ENQ; cmd_kv = kv_of(8'd5);
        tick();
        check("enq_first_latency", pq_enq, 0);
        cmd_kv = kv_of(8'd3);
        tick();
        check("enq5", {pq_enq, pq_kvi, count}, {1'b1, kv_of(8'd5), 3'd1});
        cmd_kv = kv_of(8'd9);
        tick();
        check("enq3", {pq_enq, pq_kvi, count}, {1'b1, kv_of(8'd3), 3'd2});
        cmd_valid = 1'b0;
        tick();
        check("enq9", {pq_enq, pq_kvi, count}, {1'b1, kv_of(8'd9), 3'd3});
        tick();
        check("enq_done", pq_enq, 0);

        // Deq x3 returns keys in ascending order
        do_deq("deq_a", 8'd3, 3'd2);
        do_deq("deq_b", 8'd5, 3'd1);
        do_deq("deq_c", 8'd9, 3'd0);
        check("deq_no_unf", n_unf - u0, 0);

        // Five enqs into a capacity-4 queue
        e0 = n_enq;
        for (int k = 0; k < 5; k++) begin
            cmd_valid = 1'b1; cmd_op = c_OP_ENQ; cmd_kv = kv_of(8'(10 + k));
            tick();
        end
        cmd_valid = 1'b0;
        tick();
        check("ovf_pulse", {ovf, pq_enq, count}, {1'b1, 1'b0, 3'd4});
        tick();
        check("ovf_once", ovf, 0);
        check("ovf_strobes", n_enq - e0, 4);

        do_deq("drain_a", 8'd10, 3'd3);
        do_deq("drain_b", 8'd11, 3'd2);
        do_deq("drain_c", 8'd12, 3'd1);
        do_deq("drain_d", 8'd13, 3'd0);

        // Deq on empty queue, then replace on empty queue
        cmd_valid = 1'b1; cmd_op = c_OP_DEQ;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("unf_pulse", {unf, pq_deq, res_valid}, 3'b100);
        tick();
        check("unf_once", unf, 0);
        cmd_valid = 1'b1; cmd_op = c_OP_REP; cmd_kv = kv_of(8'd7);
        tick();
        cmd_valid = 1'b0;
        tick();
        check("rep_empty", {pq_enq, pq_deq, pq_kvi}, {2'b10, kv_of(8'd7)});
        check("rep_empty_cnt", {res_valid, count}, {1'b0, 3'd1});
        tick();

        // Result backpressure: deq, deq, enq, enq, enq with res_ready low
        cmd_valid = 1'b1; cmd_op = c_OP_ENQ; cmd_kv = kv_of(8'd4);
        tick();
        cmd_valid = 1'b0;
        repeat (2) tick();
        check("bp_pre_count", count, 2);
        res_ready = 1'b0;
        seq_op  = '{c_OP_DEQ, c_OP_DEQ, c_OP_ENQ, c_OP_ENQ, c_OP_ENQ};
        seq_key = '{8'd0, 8'd0, 8'd6, 8'd8, 8'd2};
        for (int k = 0; k < 5; k++) begin
            cmd_valid = 1'b1; cmd_op = seq_op[k]; cmd_kv = kv_of(seq_key[k]);
            tick();
            if (k == 1) check("bp_first_deq", {pq_deq, res_valid, res_kv, count}, {2'b11, kv_of(8'd4), 3'd1});
            if (k == 2) check("bp_stall", pq_deq, 0);
        end
        cmd_valid = 1'b0;
        check("bp_full", {cmd_ready, pq_enq, pq_deq}, 3'b000);
        tick();
        check("bp_hold", {cmd_ready, pq_enq, pq_deq, res_valid, res_kv}, {4'b0001, kv_of(8'd4)});
        res_ready = 1'b1;
        tick();
        check("bp_resume_deq", {pq_deq, res_valid, res_kv, count}, {2'b11, kv_of(8'd7), 3'd0});
        check("bp_ready_back", cmd_ready, 1);
        tick();
        check("bp_enq6", {pq_enq, pq_kvi, count, res_valid}, {1'b1, kv_of(8'd6), 3'd1, 1'b0});
        tick();
        check("bp_enq8", {pq_enq, pq_kvi, count}, {1'b1, kv_of(8'd8), 3'd2});
        tick();
        check("bp_enq2", {pq_enq, pq_kvi, count}, {1'b1, kv_of(8'd2), 3'd3});
        tick();
        check("bp_idle", pq_enq, 0);
`ifdef PQ_CMD_SHAPER_STATS_EN
        check("stats_ovf", ovf_cnt, 1);
        check("stats_unf", unf_cnt, 1);
`endif

        // ISSUE_GAP = 3: four queued enqs strobe three cycles apart
        strobes = '0; last_kvi = '0;
        for (int k = 0; k < 14; k++) begin
            cmd2_valid = (k < 4); cmd2_op = c_OP_ENQ; cmd2_kv = kv_of(8'(1 + k));
            tick();
            strobes[k] = pq_enq2;
            if (pq_enq2) last_kvi = pq_kvi2;
        end
        cmd2_valid = 1'b0;
        check("gap_strobes", strobes, 14'b00_0100_1001_0010);
        check("gap_last_kvi", last_kvi, kv_of(8'd4));
        check("gap_count", count2, 4);

        // Reset in the middle of a stream
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        cmd2_valid = 1'b1; cmd2_kv = kv_of(8'd21);
        tick();
        cmd2_kv = kv_of(8'd22);
        tick();
        check("rst_mid_pre", {pq_enq2, pq_kvi2}, {1'b1, kv_of(8'd21)});
        rst2 = 1'b1; cmd2_valid = 1'b0;
        tick();
        check("rst_mid_out", {pq_enq2, pq_deq2, ovf2, unf2, res_valid2, cmd2_ready}, 6'b0);
        check("rst_mid_data", {pq_kvi2, res_kv2, 13'd0, count2}, 35'h0);
        rst2 = 1'b0;
        e0 = n_enq2;
        repeat (10) tick();
        check("rst_mid_quiet", n_enq2 - e0, 0);
        check("rst_mid_after", {cmd2_ready, count2}, 4'b1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pq_cmd_shaper

`default_nettype wire
